// File: rtl/fpflags_accum_pkg.sv
// Shared FPU flag definitions: flag width, bit positions, CSR op codes.
// Imported by the flag queue, the accumulator top and its interface.
package fpflags_accum_pkg;

  localparam int FLGW = 5;

  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  typedef logic [FLGW-1:0] flags_t;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_WR   = 2'b01,
    CSR_SET  = 2'b10,
    CSR_CLR  = 2'b11
  } csr_op_e;

endpackage

// File: rtl/fpflags_accum_if.sv
// Issue-side handshake: per-lane flags of a new FP op with valid/ready.
// master drives InValid/InFlg/InLaneEn, slave returns InReady.
interface fpflags_accum_if #(
  parameter int NLANES = 1
);
  import fpflags_accum_pkg::*;

  logic                   InValid;
  logic                   InReady;
  logic [NLANES*FLGW-1:0] InFlg;
  logic [NLANES-1:0]      InLaneEn;

  modport master (
    output InValid,
    output InFlg,
    output InLaneEn,
    input  InReady
  );

  modport slave (
    input  InValid,
    input  InFlg,
    input  InLaneEn,
    output InReady
  );
endinterface

// File: rtl/fpflags_queue.sv
// In-order DEPTH-entry queue of merged flags for in-flight FP ops.
// Ports: push/wdata tail write, pop/rdata head read, flush, full/empty/count.
module fpflags_queue
  import fpflags_accum_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  flags_t        wdata,
  output flags_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  flags_t        mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[head];
  // A push in a flush cycle is speculative and dropped.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[tail] <= wdata;
      if (flush) begin
        // Pop (if any) already consumed; everything left is discarded.
        head <= tail;
        cnt  <= '0;
      end else begin
        if (do_push) tail <= tail + AW'(1);
        if (do_pop)  head <= head + AW'(1);
        unique case ({do_push, do_pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: rtl/fpflags_accum.sv
// Multi-lane FP exception-flag accumulator feeding fcsr.fflags.
// Ports: issue bus (in_if), commit/flush, CSR op, FFlags/Pending/Empty/FlagsDirty.
module fpflags_accum
  import fpflags_accum_pkg::*;
#(
  parameter  int NLANES = 1,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH+1)
) (
  input  logic           clk,
  input  logic           reset_n,
  fpflags_accum_if.slave in_if,
  input  logic           CommitValid,
  input  logic           Flush,
  input  logic [1:0]     CSROp,
  input  logic [4:0]     CSRData,
  output logic [4:0]     FFlags,
  output logic [CW-1:0]  Pending,
  output logic           Empty,
  output logic           FlagsDirty
);

  flags_t merged;
  flags_t head_flg;
  flags_t base;
  flags_t ff_nxt;
  logic   full;
  logic   pop;

  always_comb begin
    merged = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (in_if.InLaneEn[i]) merged = merged | in_if.InFlg[FLGW*i +: FLGW];
    end
  end

  // Ready comes from registered occupancy only, never from CommitValid.
  assign in_if.InReady = ~full;
  assign pop           = CommitValid & ~Empty;

  fpflags_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_if.InValid),
    .pop     (CommitValid),
    .flush   (Flush),
    .wdata   (merged),
    .rdata   (head_flg),
    .full    (full),
    .empty   (Empty),
    .count   (Pending)
  );

  // Commit is older than the CSR op issued in the same cycle.
  always_comb begin
    base = FFlags | (pop ? head_flg : '0);
    unique case (csr_op_e'(CSROp))
      CSR_WR:   ff_nxt = CSRData;
      CSR_SET:  ff_nxt = base | CSRData;
      CSR_CLR:  ff_nxt = base & ~CSRData;
      default:  ff_nxt = base;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      FFlags     <= '0;
      FlagsDirty <= 1'b0;
    end else begin
      FFlags     <= ff_nxt;
      FlagsDirty <= (ff_nxt != FFlags);
    end
  end

endmodule

// File: tb/tb_fpflags_accum.sv
// Self-checking bench for fpflags_accum (NLANES=4, DEPTH=4).
// Reference queue + flag model; every output is checked after each edge.
module tb_fpflags_accum;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       CommitValid;
  logic       Flush;
  logic [1:0] CSROp;
  logic [4:0] CSRData;
  logic [4:0] FFlags;
  logic [2:0] Pending;
  logic       Empty;
  logic       FlagsDirty;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];
  logic [4:0] ff_m;
  logic       dirty_m;

  fpflags_accum_if #(.NLANES(4)) bus ();

  fpflags_accum #(
    .NLANES (4),
    .DEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_if       (bus),
    .CommitValid (CommitValid),
    .Flush       (Flush),
    .CSROp       (CSROp),
    .CSRData     (CSRData),
    .FFlags      (FFlags),
    .Pending     (Pending),
    .Empty       (Empty),
    .FlagsDirty  (FlagsDirty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.InValid  = 1'b0;
    bus.InFlg    = '0;
    bus.InLaneEn = '0;
    CommitValid  = 1'b0;
    Flush        = 1'b0;
    CSROp        = 2'b00;
    CSRData      = '0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".ff"},    32'(FFlags),     32'(ff_m));
    check({tag, ".pend"},  32'(Pending),    32'(exp_q.size()));
    check({tag, ".empty"}, 32'(Empty),      32'(exp_q.size() == 0));
    check({tag, ".dirty"}, 32'(FlagsDirty), 32'(dirty_m));
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic step(input string tag, input bit v,
                      input logic [19:0] flg, input logic [3:0] en,
                      input bit cm, input bit fl,
                      input logic [1:0] op, input logic [4:0] d);
    logic [4:0] mrg;
    logic [4:0] base;
    logic [4:0] nxt;
    bit         acc;
    bus.InValid  = v;
    bus.InFlg    = flg;
    bus.InLaneEn = en;
    CommitValid  = cm;
    Flush        = fl;
    CSROp        = op;
    CSRData      = d;
    acc = exp_q.size() < 4;
    #1;
    check({tag, ".rdy"}, 32'(bus.InReady), 32'(acc));
    mrg = '0;
    for (int i = 0; i < 4; i++)
      if (en[i]) mrg |= flg[5*i +: 5];
    base = ff_m;
    if (cm && exp_q.size() > 0) base |= exp_q.pop_front();
    case (op)
      2'b01:   nxt = d;
      2'b10:   nxt = base | d;
      2'b11:   nxt = base & ~d;
      default: nxt = base;
    endcase
    if (v && acc) exp_q.push_back(mrg);
    if (fl) exp_q.delete();
    dirty_m = (nxt != ff_m);
    ff_m    = nxt;
    @(posedge clk);
    #1;
    check_outs(tag);
    idle();
  endtask

  task automatic push1(input string tag, input logic [4:0] f);
    step(tag, 1'b1, {15'd0, f}, 4'b0001, 1'b0, 1'b0, 2'b00, 5'd0);
  endtask

  task automatic commit1(input string tag);
    step(tag, 1'b0, 20'd0, 4'd0, 1'b1, 1'b0, 2'b00, 5'd0);
  endtask

  task automatic csr(input string tag, input logic [1:0] op,
                     input logic [4:0] d);
    step(tag, 1'b0, 20'd0, 4'd0, 1'b0, 1'b0, op, d);
  endtask

  task automatic nop(input string tag);
    step(tag, 1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 2'b00, 5'd0);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    ff_m    = '0;
    dirty_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_outs("reset");
    check("reset.rdy", 32'(bus.InReady), 32'd1);

    // 1: lane merge with lane 2 masked off
    step("t1.push", 1'b1, 20'h04001, 4'b0011, 1'b0, 1'b0, 2'b00, 5'd0);
    commit1("t1.commit");
    nop("t1.idle");
    step("t1.nolane", 1'b1, 20'hFFFFF, 4'b0000, 1'b0, 1'b0, 2'b00, 5'd0);
    commit1("t1.zc");

    // 2: fill, overflow ignored, full push+pop, drain
    csr("t2.clr", 2'b01, 5'd0);
    push1("t2.p0", 5'h01);
    push1("t2.p1", 5'h02);
    push1("t2.p2", 5'h04);
    push1("t2.p3", 5'h08);
    push1("t2.ovf", 5'h10);
    step("t2.fullpp", 1'b1, 20'h00010, 4'b0001, 1'b1, 1'b0, 2'b00, 5'd0);
    step("t2.pp", 1'b1, 20'h00010, 4'b0001, 1'b1, 1'b0, 2'b00, 5'd0);
    for (int i = 0; i < 4; i++) commit1("t2.drain");
    commit1("t2.emptycm");
    csr("t2.clr2", 2'b01, 5'd0);
    push1("t2.q0", 5'h01);
    push1("t2.q1", 5'h02);
    push1("t2.q2", 5'h04);
    push1("t2.q3", 5'h08);
    for (int i = 0; i < 4; i++) commit1("t2.d2");
    check("t2.final", 32'(FFlags), 32'h0F);

    // 3: flush with same-cycle commit and push
    csr("t3.clr", 2'b01, 5'd0);
    push1("t3.p0", 5'h10);
    push1("t3.p1", 5'h04);
    push1("t3.p2", 5'h01);
    step("t3.flush", 1'b1, 20'h00002, 4'b0001, 1'b1, 1'b1, 2'b00, 5'd0);
    commit1("t3.cm1");
    commit1("t3.cm2");
    check("t3.final", 32'(FFlags), 32'h10);

    // 4: commit older than CSR clear
    csr("t4.wr", 2'b01, 5'b00110);
    push1("t4.p", 5'b00001);
    step("t4.cmclr", 1'b0, 20'd0, 4'd0, 1'b1, 1'b0, 2'b11, 5'b00011);
    check("t4.final", 32'(FFlags), 32'b00100);

    // 5: redundant writes give no dirty pulse
    csr("t5.wr1", 2'b01, 5'h1F);
    csr("t5.wr2", 2'b01, 5'h1F);
    csr("t5.set0", 2'b10, 5'h00);
    csr("t5.set", 2'b10, 5'h00);
    csr("t5.clr", 2'b11, 5'b10001);

    // 6: async reset mid-cycle with entries pending
    push1("t6.p0", 5'h08);
    push1("t6.p1", 5'h02);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    ff_m    = '0;
    dirty_m = 1'b0;
    check_outs("t6.rst");
    @(negedge clk);
    reset_n = 1'b1;
    push1("t6.after", 5'h04);
    commit1("t6.cm");
    check("t6.final", 32'(FFlags), 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
